// File: rtl/pagerank_pkg.sv
// Shared types and helpers for the pagerank gather datapath.
// Values are unsigned Q32.32 fixed point.
package pagerank_pkg;

    localparam int FRAC_BITS = 32;

    typedef logic [63:0] fixed_t;

    typedef enum logic [1:0] {
        ACCUM,
        APPLY,
        DONE
    } gather_state_t;

    function automatic fixed_t sat_add(input fixed_t a, input fixed_t b);
        logic [64:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[64] ? '1 : s[63:0];
    endfunction

endpackage

// File: rtl/counter32_bit.sv
// 32-bit up counter with synchronous clear and count enable.
// Clear takes priority over enable.
module counter32_bit (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        clear,
    output logic [31:0] count
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/pagerank_damp_unit.sv
// Combinational damping stage: rank = base + (damping * acc) >> FRAC_BITS.
// The final add saturates; the product never exceeds 96 bits.
module pagerank_damp_unit
    import pagerank_pkg::*;
(
    input  fixed_t acc,
    input  fixed_t damping,
    input  fixed_t base,
    output fixed_t rank
);

    fixed_t scaled;

    assign scaled = 64'(({64'd0, damping} * {64'd0, acc}) >> FRAC_BITS);
    assign rank   = sat_add(base, scaled);

endmodule

// File: rtl/pagerank_gather.sv
// Gathers scatter updates into per-node sums, then damps one node per cycle.
// Define PAGERANK_GATHER_DELTA_EN to build the convergence_delta accumulator.
module pagerank_gather
    import pagerank_pkg::*;
#(
    parameter int     NODES_IN_GRAPH = 32,
    parameter fixed_t DAMPING        = 64'h0000_0000_D999_999A
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               pagerank_enable,
    input  logic                               next_iteration,
    input  logic                               update_valid,
    input  logic [63:0]                        update_value,
    input  logic [31:0]                        update_node_id,
    input  logic                               scatter_done,
    output fixed_t [NODES_IN_GRAPH-1:0]        page_rank_new,
    output logic                               iteration_done,
    output logic [15:0]                        drop_count,
    output logic [63:0]                        convergence_delta
);

    localparam int     IDX_W     = (NODES_IN_GRAPH > 1) ? $clog2(NODES_IN_GRAPH) : 1;
    localparam fixed_t ONE       = 64'h1_0000_0000;
    localparam fixed_t INIT_RANK = ONE / 64'(NODES_IN_GRAPH);
    localparam fixed_t BASE      = (ONE - DAMPING) / 64'(NODES_IN_GRAPH);

    gather_state_t    state;
    fixed_t           acc [NODES_IN_GRAPH];
    logic [31:0]      k;
    logic [IDX_W-1:0] k_idx;
    logic [IDX_W-1:0] id_idx;
    logic             in_range;
    logic             drop;
    logic             k_clear;
    logic             k_en;
    logic             last_node;
    fixed_t           damped;

    assign k_idx     = k[IDX_W-1:0];
    assign id_idx    = update_node_id[IDX_W-1:0];
    assign in_range  = update_node_id < 32'(NODES_IN_GRAPH);
    assign drop      = update_valid && (state != ACCUM || !in_range);
    assign last_node = k == 32'(NODES_IN_GRAPH - 1);

    assign k_en    = pagerank_enable && state == APPLY;
    assign k_clear = pagerank_enable
                   && ((state == ACCUM && scatter_done)
                   ||  (state == DONE && next_iteration));

    counter32_bit u_node_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (k_en),
        .clear   (k_clear),
        .count   (k)
    );

    pagerank_damp_unit u_damp (
        .acc     (acc[k_idx]),
        .damping (DAMPING),
        .base    (BASE),
        .rank    (damped)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ACCUM;
            drop_count     <= '0;
            iteration_done <= 1'b0;
            for (int i = 0; i < NODES_IN_GRAPH; i++) begin
                acc[i]           <= '0;
                page_rank_new[i] <= INIT_RANK;
            end
        end else if (pagerank_enable) begin
            if (drop && drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
            unique case (state)
                ACCUM: begin
                    // Same-cycle update lands before the apply pass reads acc.
                    if (update_valid && in_range) begin
                        acc[id_idx] <= sat_add(acc[id_idx], update_value);
                    end
                    if (scatter_done) begin
                        state <= APPLY;
                    end
                end
                APPLY: begin
                    page_rank_new[k_idx] <= damped;
                    if (last_node) begin
                        state          <= DONE;
                        iteration_done <= 1'b1;
                    end
                end
                DONE: begin
                    if (next_iteration) begin
                        state          <= ACCUM;
                        iteration_done <= 1'b0;
                        for (int i = 0; i < NODES_IN_GRAPH; i++) begin
                            acc[i] <= '0;
                        end
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

`ifdef PAGERANK_GATHER_DELTA_EN
    fixed_t delta;
    fixed_t old_rank;
    fixed_t diff;

    assign old_rank = page_rank_new[k_idx];
    assign diff     = (damped >= old_rank) ? damped - old_rank : old_rank - damped;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            delta <= '0;
        end else if (pagerank_enable) begin
            if (state == ACCUM && scatter_done) begin
                delta <= '0;
            end else if (state == APPLY) begin
                delta <= sat_add(delta, diff);
            end
        end
    end

    assign convergence_delta = delta;
`else
    assign convergence_delta = '0;
`endif

endmodule
